// File: rtl/piso_pkg.sv
// Shared definitions for the piso_reader slice: FSM encoding and bit-counter sizing.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Wide enough to hold DW+1 (parity build) without wrapping.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 2);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit counter for piso_reader: synchronous clear, count enable, terminal-count flag at NBITS-1.
module piso_bit_counter #(
  parameter int NBITS = 8,
  parameter int CW    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(NBITS - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/piso_reader.sv
// Parallel-in serial-out reader with step handshake and one-cycle done pulse.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_reader
  import piso_pkg::*;
#(
  parameter int DW        = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [DW-1:0] data_in,
  input  logic          step,
  output logic          ready,
  output logic          sout,
  output logic          sout_valid,
  output logic          done
);

`ifdef PISO_PARITY_EN
  localparam int NBITS = DW + 1;
`else
  localparam int NBITS = DW;
`endif
  localparam int CW = cnt_width(DW);

  // Handshake: a bit on sout is offered while sout_valid=1 and is consumed
  // on each rising edge where step=1; step outside SHIFT is ignored.
  state_t           state, state_nxt;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] load_val;
  logic             accept;
  logic             adv;
  logic             tc;
  logic             head;

  assign accept = (state == ST_IDLE) && ld;
  assign adv    = (state == ST_SHIFT) && step;

  // Parity is placed so that it leaves the register after the last data bit.
  always_comb begin
`ifdef PISO_PARITY_EN
    if (MSB_FIRST) load_val = {data_in, ^data_in};
    else           load_val = {^data_in, data_in};
`else
    load_val = data_in;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= load_val;
    end else if (adv) begin
      if (MSB_FIRST) shreg <= {shreg[NBITS-2:0], 1'b0};
      else           shreg <= {1'b0, shreg[NBITS-1:1]};
    end
  end

  piso_bit_counter #(
    .NBITS(NBITS),
    .CW   (CW)
  ) u_bit_counter (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en (adv),
    .tc (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (ld) state_nxt = ST_SHIFT;
      ST_SHIFT: if (step && tc) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign head       = MSB_FIRST ? shreg[NBITS-1] : shreg[0];
  assign ready      = (state == ST_IDLE);
  assign sout_valid = (state == ST_SHIFT);
  assign sout       = (state == ST_SHIFT) ? head : 1'b0;
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_piso_reader.sv
// Directed bench for piso_reader: an MSB-first and an LSB-first instance share stimulus.
module tb_piso_reader;

`ifdef PISO_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk;
  logic       rst;
  logic       ld;
  logic [7:0] data_in;
  logic       step;

  logic m_ready, m_sout, m_sout_valid, m_done;
  logic l_ready, l_sout, l_sout_valid, l_done;

  int n_total;
  int n_pass;

  typedef struct {
    logic [7:0] word;
    logic [7:0] msb_seq;   // bit 7 is the first bit out
    logic [7:0] lsb_seq;
    logic       par;
    int         stall_at;
    int         stall_len;
    logic       busy;
  } vec_t;

  vec_t vecs[6];

  piso_reader #(.DW(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .ld(ld), .data_in(data_in), .step(step),
    .ready(m_ready), .sout(m_sout), .sout_valid(m_sout_valid), .done(m_done)
  );

  piso_reader #(.DW(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .ld(ld), .data_in(data_in), .step(step),
    .ready(l_ready), .sout(l_sout), .sout_valid(l_sout_valid), .done(l_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " m_ready"}, m_ready, 1'b1);
    check({tag, " m_valid"}, m_sout_valid, 1'b0);
    check({tag, " m_sout"}, m_sout, 1'b0);
    check({tag, " m_done"}, m_done, 1'b0);
    check({tag, " l_ready"}, l_ready, 1'b1);
    check({tag, " l_done"}, l_done, 1'b0);
  endtask

  task automatic check_bit(input string tag, input logic em, input logic el);
    check({tag, " m_sout"}, m_sout, em);
    check({tag, " m_valid"}, m_sout_valid, 1'b1);
    check({tag, " m_ready"}, m_ready, 1'b0);
    check({tag, " l_sout"}, l_sout, el);
    check({tag, " l_valid"}, l_sout_valid, 1'b1);
    check({tag, " m_done"}, m_done, 1'b0);
  endtask

  // Drives are applied at the falling edge, after that cycle's outputs are checked.
  task automatic run_word(input vec_t v, input int idx);
    logic em, el;
    string tag;
    @(negedge clk);
    ld = 1'b1; data_in = v.word; step = 1'b0;
    @(negedge clk);
    ld = 1'b0; data_in = ~v.word;
    for (int b = 0; b < NB; b++) begin
      em = (b < 8) ? v.msb_seq[7-b] : v.par;
      el = (b < 8) ? v.lsb_seq[7-b] : v.par;
      tag = $sformatf("v%0d b%0d", idx, b);
      check_bit(tag, em, el);
      if (b == v.stall_at) begin
        for (int s = 0; s < v.stall_len; s++) begin
          step = 1'b0;
          @(negedge clk);
          check_bit($sformatf("v%0d stall%0d", idx, s), em, el);
        end
      end
      step = 1'b1;
      if (v.busy && b == 3) begin
        ld = 1'b1; data_in = 8'hFF;
      end else begin
        ld = 1'b0;
      end
      @(negedge clk);
    end
    step = 1'b0; ld = 1'b0;
    tag = $sformatf("v%0d end", idx);
    check({tag, " m_done"}, m_done, 1'b1);
    check({tag, " l_done"}, l_done, 1'b1);
    check({tag, " m_valid"}, m_sout_valid, 1'b0);
    check({tag, " m_ready"}, m_ready, 1'b0);
    @(negedge clk);
    check_idle($sformatf("v%0d post", idx));
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1; ld = 1'b0; data_in = 8'h00; step = 1'b0;

    vecs[0] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0, -1, 0, 1'b0};
    vecs[1] = '{8'h01, 8'b00000001, 8'b10000000, 1'b1, -1, 0, 1'b0};
    vecs[2] = '{8'hF0, 8'b11110000, 8'b00001111, 1'b0,  2, 3, 1'b0};
    vecs[3] = '{8'h0F, 8'b00001111, 8'b11110000, 1'b0, -1, 0, 1'b1};
    vecs[4] = '{8'h07, 8'b00000111, 8'b11100000, 1'b1, -1, 0, 1'b0};
    vecs[5] = '{8'hD2, 8'b11010010, 8'b01001011, 1'b0, -1, 0, 1'b0};

    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    // step while idle must not start anything
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check_idle("idle_step");

    for (int i = 0; i < 6; i++) run_word(vecs[i], i);

    // Mid-word reset after four bits have been consumed.
    @(negedge clk);
    ld = 1'b1; data_in = 8'hA5;
    @(negedge clk);
    ld = 1'b0; step = 1'b1;
    repeat (4) @(negedge clk);
    check_bit("pre_rst", vecs[0].msb_seq[3], vecs[0].lsb_seq[3]);
    rst = 1'b1; step = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_idle("mid_rst");
    for (int c = 0; c < NB + 2; c++) begin
      @(negedge clk);
      check($sformatf("rst_no_done c%0d m", c), m_done, 1'b0);
      check($sformatf("rst_no_done c%0d l", c), l_done, 1'b0);
    end
    run_word('{8'h3C, 8'b00111100, 8'b00111100, 1'b0, -1, 0, 1'b0}, 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/piso_reader.md
# piso_reader

Parallel-in, serial-out reader that drains a word from the register file datapath one bit per accepted step. It is the consumer counterpart of the load-enabled storage register. It captures `data_in` on a `ld` request while idle and presents it bit-serially on `sout`, pacing each bit with a `step` handshake. Completion is signalled with a one-cycle `done` pulse.

## Interface
- `DW`, default 8: data word width, ≥ 2.
- `MSB_FIRST`, default 1: 1 = shift bit DW-1 first, 0 = bit 0 first.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ld`  in  1  load request; honoured only when `ready`=1.
- `data_in`  in  DW  word to serialise; sampled on an accepted `ld`.
- `step`  in  1  consumer has taken the current `sout` bit; advance.
- `ready`  out  1  idle, can accept `ld`.
- `sout`  out  1  current serial bit.
- `sout_valid`  out  1  `sout` holds a valid bit.
- `done`  out  1  one-cycle pulse after the last bit is consumed.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `ready`=1, `sout_valid`=0, `sout`=0.
  - `ld`=1 latches `data_in` into the shift register, clears the bit counter, and moves to SHIFT.
- SHIFT:
  - `sout_valid`=1; `sout` = current head bit. MSB_FIRST=1 gives shreg[DW-1]; MSB_FIRST=0 gives shreg[0].
  - `step`=1: shift by one (MSB_FIRST=1 shifts left, 0 shifts right; vacated bit filled with 0) and increment the counter.
  - `step`=1 with counter == NBITS-1: go to DONE.
  - `step`=0: hold all state; `sout` remains stable.
- DONE:
  - `done`=1 for exactly one cycle; `sout_valid`=0.
  - Unconditional transition to IDLE.
- NBITS = DW, or DW+1 when parity is enabled (see Configuration).
- Counter width is $clog2(DW+2). The counter never wraps: it is cleared on load and saturates by leaving SHIFT.
- `ld` while not IDLE is ignored. It is neither queued nor able to corrupt the current word.
- `data_in` changes after acceptance have no effect.
- `rst` has priority over every other input. It forces IDLE in the same edge and discards any in-flight word. After reset, no `done` is generated for the discarded word.
- Reset values:
  - `ready`=1, `sout`=0, `sout_valid`=0, `done`=0.
  - Shift register = 0; counter = 0.

## Timing
- `ld` accepted at edge k: `sout_valid`=1 and the first bit is on `sout` after edge k (cycle k+1). `ready`=0 from cycle k+1.
- Each `step`=1 cycle in SHIFT presents the next bit after that edge. Minimum word time is NBITS cycles with `step` held high.
- The last `step` at edge m: `done`=1 in cycle m+1, `ready`=1 in cycle m+2. The next `ld` can be accepted at edge m+2.
- Throughput with continuous `step` and back-to-back loads: one word per NBITS+2 cycles.
- Outputs are registered, or decoded from registered state only. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `PISO_PARITY_EN`.
- Defined:
  - An even-parity bit (XOR of all DW data bits, computed from `data_in` at load) is appended after the last data bit.
  - NBITS = DW+1, and `sout_valid` stays high for the parity bit.
- Undefined:
  - No parity logic; NBITS = DW.

## Structure
- Shared package `piso_pkg` holds:
  - The FSM state encoding: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - The counter-width function/constant.
- One sub-module, `piso_bit_counter` (clear, enable, terminal-count compare against NBITS-1, tc output).
  - Instantiated once.
  - The shift register and FSM live in `piso_reader`.

## Test plan
- Reset, MSB-first: DW=8, `ld` with 8'hA5, `step` held 1 → `sout` sequence 1,0,1,0,0,1,0,1 over cycles k+1..k+8; `done` at k+9; `ready` at k+10.
- LSB-first: MSB_FIRST=0, load 8'h01 → `sout` 1 then seven 0s.
- Stall: load 8'hF0 and drop `step` for 3 cycles after the second bit → `sout` holds 1 for the stall duration; the sequence completes unaltered; `done` is delayed by 3 cycles.
- Busy load: assert `ld` with 8'hFF mid-word (original 8'h0F) → output remains 0,0,0,0,1,1,1,1; only one `done` pulse.
- Mid-word reset: `rst` after the 4th bit → next cycle `ready`=1, `sout_valid`=0, no `done`. A fresh load of 8'h3C then serialises correctly.
- `PISO_PARITY_EN` defined: load 8'h07 → 8 data bits followed by parity bit 1; `done` one cycle later than in the no-parity build.
